// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned LEN_W          = 16;
    localparam int unsigned BYTES_PER_WORD = 4;

    localparam logic [BYTE_W-1:0] SYNC_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    // True while a frame is being received (header, payload or checksum).
    function automatic logic in_frame(input state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CHECK);
    endfunction

    // True in every state that takes bytes from the stream.
    function automatic logic accepts_bytes(input state_t s);
        return (s == IDLE) || in_frame(s);
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs big-endian bytes into 32-bit words and flags the byte that completes a word.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word_c,
    output logic              word_done_c
);

    localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);
    localparam int unsigned SR_W  = WORD_W - BYTE_W;

    logic [CNT_W-1:0] cnt;
    logic [SR_W-1:0]  sr;

    // The current byte lands in the low lane, earlier bytes move up.
    assign word_c      = {sr, byte_in};
    assign word_done_c = shift_en && (cnt == CNT_W'(BYTES_PER_WORD - 1));

    // Byte position counter and shift register of the bytes seen so far.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sr  <= '0;
        end else if (clear) begin
            cnt <= '0;
            sr  <= '0;
        end else if (shift_en) begin
            cnt <= cnt + CNT_W'(1);
            sr  <= word_c[SR_W-1:0];
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a framed byte stream, writes code memory, releases the core.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 10,
    parameter int unsigned       START_ADDR = 0,
    parameter logic [BYTE_W-1:0] SYNC       = SYNC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_en,
    output logic              busy,
    output logic              err
);

    // One extra index bit so a full-memory load is counted without wrapping.
    localparam int unsigned IDX_W    = ADDR_W + 1;
    localparam int unsigned CAPACITY = (32'd1 << ADDR_W) - START_ADDR;

    state_t state;
    state_t state_nxt;

    logic [BYTE_W-1:0] len_hi;
    logic [LEN_W-1:0]  len;
    logic [IDX_W-1:0]  idx;
    logic [BYTE_W-1:0] chk;

    logic              accept_c;
    logic              shift_en_c;
    logic              pack_clear_c;
    logic              rearm_c;
    logic              last_word_c;
    logic [LEN_W-1:0]  len_in_c;
    logic [WORD_W-1:0] word_c;
    logic              word_done_c;

    assign accept_c     = in_valid && in_ready;
    assign shift_en_c   = accept_c && (state == DATA);
    assign pack_clear_c = (state == IDLE);
    assign rearm_c      = start && ((state == DONE) || (state == ERROR));
    assign len_in_c     = {len_hi, in_data};
    assign last_word_c  = ((32'(idx) + 32'd1) == 32'(len));

    byte_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (pack_clear_c),
        .shift_en    (shift_en_c),
        .byte_in     (in_data),
        .word_c      (word_c),
        .word_done_c (word_done_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: header parse, range check, payload count, checksum verdict.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept_c && (in_data == SYNC)) begin
                    state_nxt = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept_c) begin
                    state_nxt = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept_c) begin
                    if (32'(len_in_c) > CAPACITY) begin
                        state_nxt = ERROR;
                    end else if (len_in_c == '0) begin
                        state_nxt = CHECK;
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (word_done_c && last_word_c) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (accept_c) begin
                    state_nxt = (in_data == chk) ? DONE : ERROR;
                end
            end
            DONE, ERROR: begin
                if (start) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Frame datapath: word count capture, payload checksum and word index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_hi <= '0;
            len    <= '0;
            idx    <= '0;
            chk    <= '0;
        end else if (rearm_c) begin
            idx <= '0;
            chk <= '0;
        end else if (accept_c) begin
            case (state)
                LEN_HI: len_hi <= in_data;
                LEN_LO: len    <= len_in_c;
                DATA: begin
                    chk <= chk ^ in_data;
                    if (word_done_c) begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Status outputs registered from the next state so they track it cycle-exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            cpu_en   <= 1'b0;
            err      <= 1'b0;
        end else begin
            in_ready <= accepts_bytes(state_nxt);
            busy     <= in_frame(state_nxt);
            cpu_en   <= (state_nxt == DONE);
            err      <= (state_nxt == ERROR);
        end
    end

    // Memory write port: one-cycle strobe, address and data held until the next write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= ADDR_W'(START_ADDR);
            mem_wdata <= '0;
        end else begin
            mem_we <= word_done_c;
            if (word_done_c) begin
                mem_addr  <= ADDR_W'(START_ADDR + 32'(idx));
                mem_wdata <= word_c;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader against a frame-level reference model.
module tb_imem_loader;

    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned START_ADDR = 0;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_en;
    logic              busy;
    logic              err;

    imem_loader #(.ADDR_W(ADDR_W), .START_ADDR(START_ADDR), .SYNC(8'hA5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_en    (cpu_en),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]        tx[$];
    logic [ADDR_W-1:0] got_addr[$];
    logic [31:0]       got_data[$];
    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_data[$];
    int                exp_error;
    int                we_double = 0;
    logic              prev_we = 1'b0;

    // Write monitor: logs every strobe and counts strobes longer than one cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            got_addr.push_back(mem_addr);
            got_data.push_back(mem_wdata);
            if (prev_we) we_double++;
        end
        prev_we = mem_we;
    end

    // Reference model: parse tx as a frame and derive writes and final verdict.
    task automatic model_frame();
        int         i = 0;
        int         len;
        logic [31:0] w;
        logic [7:0]  x = 8'h00;
        exp_addr.delete();
        exp_data.delete();
        while (i < tx.size() && tx[i] != 8'hA5) i++;
        i++;
        len = (int'(tx[i]) << 8) | int'(tx[i+1]);
        i += 2;
        if (len > (1 << ADDR_W) - int'(START_ADDR)) begin
            exp_error = 1;
            return;
        end
        for (int k = 0; k < len; k++) begin
            w = 32'h0;
            for (int b = 0; b < 4; b++) begin
                w = (w << 8) | 32'(tx[i]);
                x = x ^ tx[i];
                i++;
            end
            exp_addr.push_back(ADDR_W'(int'(START_ADDR) + k));
            exp_data.push_back(w);
        end
        exp_error = (tx[i] == x) ? 0 : 1;
    endtask

    task automatic build_spec_frame(input logic [7:0] chk);
        tx = '{8'hA5, 8'h00, 8'h04,
               8'h03, 8'hE0, 8'hA8, 8'h00,
               8'h07, 8'hE0, 8'hA8, 8'h00,
               8'h0B, 8'hE0, 8'hA8, 8'h00,
               8'h0F, 8'hE0, 8'hA8, 8'h00};
        tx.push_back(chk);
    endtask

    // Called at a falling edge; returns at the falling edge after the byte is taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited = 0;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL handshake_timeout: byte %02h in_ready=%0b, required 1", b, in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input int gap_max);
        for (int i = 0; i < tx.size(); i++) begin
            send_byte(tx[i], (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0);
        end
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_en, busy, err} !== '0) begin
            miscompares++;
            $display("FAIL reset_values: in_ready=%0b we=%0b addr=%0h wdata=%0h cpu_en=%0b busy=%0b err=%0b, required all 0",
                     in_ready, mem_we, mem_addr, mem_wdata, cpu_en, busy, err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: in_ready=%0b busy=%0b, required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_load();
        do_start();
        build_spec_frame(8'h00);
        model_frame();
        for (int i = 0; i < tx.size(); i++) begin
            if (i == tx.size() - 1) begin
                vectors++;
                if (cpu_en !== 1'b0) begin
                    miscompares++;
                    $display("FAIL load_cpu_en_early: got %0b, required 0", cpu_en);
                end
            end
            send_byte(tx[i], 0);
            if (i == 0) begin
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL load_busy: got %0b, required 1", busy);
                end
            end
        end
        in_valid = 1'b0;
        vectors++;
        if ({cpu_en, err, in_ready, busy} !== 4'b1000) begin
            miscompares++;
            $display("FAIL load_done: cpu_en/err/in_ready/busy=%04b, required 1000", {cpu_en, err, in_ready, busy});
        end
        vectors++;
        if (got_addr.size() != exp_addr.size() || we_double != 0) begin
            miscompares++;
            $display("FAIL load_write_count: got %0d (doubled %0d), required %0d", got_addr.size(), we_double, exp_addr.size());
        end
        for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
            vectors++;
            if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k]) begin
                miscompares++;
                $display("FAIL load_write%0d: got %0h:%08h, required %0h:%08h", k, got_addr[k], got_data[k], exp_addr[k], exp_data[k]);
            end
        end
        vectors++;
        if (got_data.size() > 3 && got_data[3] !== 32'h0FE0A800) begin
            miscompares++;
            $display("FAIL load_word3: got %08h, required 0fe0a800", got_data[3]);
        end
    endtask

    task automatic test_bad_chk();
        do_start();
        build_spec_frame(8'h01);
        model_frame();
        send_frame(0);
        vectors++;
        if ({err, cpu_en, in_ready} !== 3'b100) begin
            miscompares++;
            $display("FAIL badchk_state: err/cpu_en/in_ready=%03b, required 100", {err, cpu_en, in_ready});
        end
        vectors++;
        if (got_addr.size() != 4 || exp_error != 1) begin
            miscompares++;
            $display("FAIL badchk_writes: got %0d writes, model err %0d, required 4 and 1", got_addr.size(), exp_error);
        end
        do_start();
        vectors++;
        if ({err, in_ready, cpu_en} !== 3'b010) begin
            miscompares++;
            $display("FAIL badchk_rearm: err/in_ready/cpu_en=%03b, required 010", {err, in_ready, cpu_en});
        end
    endtask

    task automatic test_junk_gaps();
        do_start();
        build_spec_frame(8'h00);
        tx.push_front(8'h5A);
        tx.push_front(8'hFF);
        tx.push_front(8'h00);
        model_frame();
        send_frame(3);
        vectors++;
        if (cpu_en !== 1'b1 || err !== 1'b0 || got_addr.size() != exp_addr.size()) begin
            miscompares++;
            $display("FAIL junk_outcome: cpu_en=%0b err=%0b writes=%0d, required 1 0 %0d", cpu_en, err, got_addr.size(), exp_addr.size());
        end
        for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
            vectors++;
            if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k]) begin
                miscompares++;
                $display("FAIL junk_write%0d: got %0h:%08h, required %0h:%08h", k, got_addr[k], got_data[k], exp_addr[k], exp_data[k]);
            end
        end
    endtask

    task automatic test_len_bounds();
        do_start();
        tx = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_frame(1);
        vectors++;
        if (cpu_en !== 1'b1 || got_addr.size() != 0) begin
            miscompares++;
            $display("FAIL len0: cpu_en=%0b writes=%0d, required 1 0", cpu_en, got_addr.size());
        end
        do_start();
        tx = '{8'hA5, 8'h04, 8'h01};
        send_frame(0);
        vectors++;
        if ({err, in_ready, cpu_en} !== 3'b100 || got_addr.size() != 0) begin
            miscompares++;
            $display("FAIL len_over: err/in_ready/cpu_en=%03b writes=%0d, required 100 0", {err, in_ready, cpu_en}, got_addr.size());
        end
    endtask

    task automatic test_reset_mid();
        do_start();
        build_spec_frame(8'h00);
        for (int i = 0; i < 9; i++) send_byte(tx[i], 0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_en, busy, err} !== '0) begin
            miscompares++;
            $display("FAIL midreset_values: in_ready=%0b we=%0b addr=%0h wdata=%0h cpu_en=%0b busy=%0b err=%0b, required all 0",
                     in_ready, mem_we, mem_addr, mem_wdata, cpu_en, busy, err);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        got_addr.delete();
        got_data.delete();
        model_frame();
        send_frame(0);
        vectors++;
        if (cpu_en !== 1'b1 || got_addr.size() != exp_addr.size()) begin
            miscompares++;
            $display("FAIL midreset_reload: cpu_en=%0b writes=%0d, required 1 %0d", cpu_en, got_addr.size(), exp_addr.size());
        end
        for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
            vectors++;
            if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k]) begin
                miscompares++;
                $display("FAIL midreset_write%0d: got %0h:%08h, required %0h:%08h", k, got_addr[k], got_data[k], exp_addr[k], exp_data[k]);
            end
        end
    endtask

    task automatic test_full_load();
        logic [7:0] x = 8'h00;
        logic [31:0] w;
        logic [7:0] b;
        int bad = 0;
        do_start();
        tx = '{8'hA5, 8'h04, 8'h00};
        for (int k = 0; k < 1024; k++) begin
            w = 32'(k);
            for (int j = 3; j >= 0; j--) begin
                b = w[j*8 +: 8];
                tx.push_back(b);
                x = x ^ b;
            end
        end
        tx.push_back(x);
        model_frame();
        send_frame(0);
        vectors++;
        if (cpu_en !== 1'b1 || got_addr.size() != 1024) begin
            miscompares++;
            $display("FAIL full_outcome: cpu_en=%0b writes=%0d, required 1 1024", cpu_en, got_addr.size());
        end
        vectors++;
        if (got_addr.size() == 0 || got_addr[got_addr.size()-1] !== 10'd1023 || got_data[got_data.size()-1] !== 32'h000003FF) begin
            miscompares++;
            $display("FAIL full_last: got %0h:%08h, required 3ff:000003ff",
                     (got_addr.size() > 0) ? got_addr[got_addr.size()-1] : '0,
                     (got_data.size() > 0) ? got_data[got_data.size()-1] : '0);
        end
        for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
            if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k]) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL full_writes: %0d words differ, required 0", bad);
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic [7:0]  x;
        int          len;
        for (int it = 0; it < 20; it++) begin
            do_start();
            len = int'($urandom_range(6, 1));
            tx = '{8'hA5, 8'h00, 8'(len)};
            x = 8'h00;
            for (int k = 0; k < len; k++) begin
                w = $urandom;
                for (int j = 3; j >= 0; j--) begin
                    tx.push_back(w[j*8 +: 8]);
                    x = x ^ w[j*8 +: 8];
                end
            end
            tx.push_back(($urandom_range(3, 0) == 0) ? (x ^ 8'(1 << $urandom_range(7, 0))) : x);
            model_frame();
            send_frame(2);
            vectors++;
            if (cpu_en !== (exp_error == 0) || err !== (exp_error == 1) || got_addr.size() != exp_addr.size()) begin
                miscompares++;
                $display("FAIL rand%0d_outcome: cpu_en=%0b err=%0b writes=%0d, required %0b %0b %0d",
                         it, cpu_en, err, got_addr.size(), exp_error == 0, exp_error == 1, exp_addr.size());
            end
            for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
                vectors++;
                if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k]) begin
                    miscompares++;
                    $display("FAIL rand%0d_write%0d: got %0h:%08h, required %0h:%08h", it, k, got_addr[k], got_data[k], exp_addr[k], exp_data[k]);
                end
            end
        end
        vectors++;
        if (we_double != 0) begin
            miscompares++;
            $display("FAIL we_pulse_width: %0d multi-cycle strobes, required 0", we_double);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_bad_chk();
        test_junk_gaps();
        test_len_bounds();
        test_reset_mid();
        test_full_load();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
